// File: rtl/kb_move_ctrl.sv
// PS/2 scan-code decoder that turns arrow/WASD/Enter bytes into move pulses and key-held flags.
// Optional build macro AUTO_REPEAT_EN adds periodic re-pulsing of the most recently pressed direction.
module kb_move_ctrl #(
  parameter int TIMEOUT_CYC   = 50000,
  parameter int REPEAT_PERIOD = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic [7:0] scan_code,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       start_pulse,
  output logic [3:0] held
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  typedef enum logic [1:0] {EV_NONE, EV_MAKE, EV_BREAK} event_t;

  // Direction index doubles as the bit position in held: up=3, down=2, left=1, right=0.
  localparam logic [1:0] DIR_UP    = 2'd3;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd0;

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYC);

  if (TIMEOUT_CYC < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("kb_move_ctrl: TIMEOUT_CYC and REPEAT_PERIOD must be at least 1");
  end

  state_t        state, nxt_state;
  event_t        ev;
  logic          ev_ext;
  logic          dir_hit;
  logic [1:0]    dir_idx;
  logic          start_hit;
  logic          make_new;
  logic          brk_hit;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    move_q;

  // NOTE: every signal assigned in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_state = state;
    ev        = EV_NONE;
    ev_ext    = 1'b0;
    if (scan_tick) begin
      unique case (state)
        IDLE: begin
          if (scan_code == 8'hE0)      nxt_state = EXT;
          else if (scan_code == 8'hF0) nxt_state = BRK;
          else                         ev = EV_MAKE;
        end
        EXT: begin
          if (scan_code == 8'hF0)      nxt_state = EXT_BRK;
          else if (scan_code == 8'hE0) nxt_state = EXT;
          else begin
            ev        = EV_MAKE;
            ev_ext    = 1'b1;
            nxt_state = IDLE;
          end
        end
        BRK: begin
          if (scan_code == 8'hE0) nxt_state = EXT_BRK;
          else begin
            ev        = EV_BREAK;
            nxt_state = IDLE;
          end
        end
        EXT_BRK: begin
          ev        = EV_BREAK;
          ev_ext    = 1'b1;
          nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_MAX - 1'b1) begin
      // A prefix left dangling too long is dropped so a lost byte cannot wedge the decoder.
      nxt_state = IDLE;
    end
  end

  always_comb begin
    dir_hit = 1'b0;
    dir_idx = DIR_UP;
    if (ev_ext) begin
      unique case (scan_code)
        8'h75:   begin dir_hit = 1'b1; dir_idx = DIR_UP;    end
        8'h72:   begin dir_hit = 1'b1; dir_idx = DIR_DOWN;  end
        8'h6B:   begin dir_hit = 1'b1; dir_idx = DIR_LEFT;  end
        8'h74:   begin dir_hit = 1'b1; dir_idx = DIR_RIGHT; end
        default: dir_hit = 1'b0;
      endcase
    end else begin
      unique case (scan_code)
        8'h1D:   begin dir_hit = 1'b1; dir_idx = DIR_UP;    end
        8'h1B:   begin dir_hit = 1'b1; dir_idx = DIR_DOWN;  end
        8'h1C:   begin dir_hit = 1'b1; dir_idx = DIR_LEFT;  end
        8'h23:   begin dir_hit = 1'b1; dir_idx = DIR_RIGHT; end
        default: dir_hit = 1'b0;
      endcase
    end
  end

  assign start_hit = (ev == EV_MAKE) && !ev_ext && (scan_code == 8'h5A);
  assign make_new  = (ev == EV_MAKE) && dir_hit && !held[dir_idx];
  assign brk_hit   = (ev == EV_BREAK) && dir_hit;

`ifdef AUTO_REPEAT_EN
  localparam int            RW      = $clog2(REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    last_dir;
  logic [RW-1:0] rep_cnt;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values and the result does not depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      move_q      <= '0;
      start_pulse <= 1'b0;
      held        <= '0;
`ifdef AUTO_REPEAT_EN
      last_dir    <= DIR_UP;
      rep_cnt     <= '0;
`endif
    end else begin
      state       <= nxt_state;
      move_q      <= '0;
      start_pulse <= start_hit;

      if (scan_tick || state == IDLE) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)    tmo_cnt <= tmo_cnt + 1'b1;

`ifdef AUTO_REPEAT_EN
      // Repeat only the latest newly-held key; a break of it stops repeating for good.
      if (held[last_dir] && !(brk_hit && dir_idx == last_dir)) begin
        if (rep_cnt == REP_MAX) begin
          rep_cnt          <= '0;
          move_q[last_dir] <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
`endif

      if (make_new) begin
        held[dir_idx]   <= 1'b1;
        move_q[dir_idx] <= 1'b1;
`ifdef AUTO_REPEAT_EN
        last_dir        <= dir_idx;
        rep_cnt         <= '0;
`endif
      end

      if (brk_hit) held[dir_idx] <= 1'b0;
    end
  end

  assign move_up    = move_q[DIR_UP];
  assign move_down  = move_q[DIR_DOWN];
  assign move_left  = move_q[DIR_LEFT];
  assign move_right = move_q[DIR_RIGHT];

endmodule

// File: tb/tb_kb_move_ctrl.sv
// Bench for kb_move_ctrl: table of scan bytes with expected outputs, plus reset/timeout/repeat sequences.
module tb_kb_move_ctrl;

  localparam int TMO = 20;
  localparam int RP  = 16;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_tick;
  logic [7:0] scan_code;
  logic       move_up, move_down, move_left, move_right, start_pulse;
  logic [3:0] held;

  kb_move_ctrl #(.TIMEOUT_CYC(TMO), .REPEAT_PERIOD(RP)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_tick  (scan_tick),
    .scan_code  (scan_code),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .start_pulse(start_pulse),
    .held       (held)
  );

  always #5 clk = ~clk;

  // move is {up, down, left, right}, same bit order as held.
  typedef struct packed {
    logic [3:0] move;
    logic       start;
    logic [3:0] held;
  } out_t;

  typedef struct {
    logic [7:0] code;
    out_t       exp;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic out_t mk(input logic [3:0] m, input logic s, input logic [3:0] h);
    out_t o;
    o.move  = m;
    o.start = s;
    o.held  = h;
    return o;
  endfunction

  task automatic add(input logic [7:0] code, input logic [3:0] m, input logic s, input logic [3:0] h);
    vec_t v;
    v.code = code;
    v.exp  = mk(m, s, h);
    vecs.push_back(v);
  endtask

  task automatic check(input string name);
    out_t act, e;
    act = mk({move_up, move_down, move_left, move_right}, start_pulse, held);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry queued, got move=%b start=%b held=%b",
               name, act.move, act.start, act.held);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s: got move=%b start=%b held=%b, expected move=%b start=%b held=%b",
                 name, act.move, act.start, act.held, e.move, e.start, e.held);
      end
    end
  endtask

  // Drives one cycle of inputs, queues the expected outputs for the following cycle, then checks them.
  task automatic step(input logic rst, input logic tick, input logic [7:0] code,
                      input out_t exp, input string name);
    reset     = rst;
    scan_tick = tick;
    scan_code = code;
    exp_q.push_back(exp);
    @(negedge clk);
    reset     = 1'b0;
    scan_tick = 1'b0;
    check(name);
  endtask

  initial begin
    reset     = 1'b1;
    scan_tick = 1'b0;
    scan_code = 8'h00;
    repeat (2) @(negedge clk);
    step(1'b1, 1'b0, 8'h00, mk(4'h0, 1'b0, 4'h0), "reset_state");

    // Back-to-back bytes; each row's expectation is the cycle after its tick.
    add(8'hE0, 4'h0, 1'b0, 4'h0);
    add(8'h75, 4'h8, 1'b0, 4'h8);   // arrow up make
    add(8'hE0, 4'h0, 1'b0, 4'h8);
    add(8'h75, 4'h0, 1'b0, 4'h8);   // typematic, no pulse
    add(8'hE0, 4'h0, 1'b0, 4'h8);
    add(8'hF0, 4'h0, 1'b0, 4'h8);
    add(8'h75, 4'h0, 1'b0, 4'h0);   // arrow up break
    add(8'h1C, 4'h2, 1'b0, 4'h2);   // A make
    add(8'hE0, 4'h0, 1'b0, 4'h2);
    add(8'h74, 4'h1, 1'b0, 4'h3);   // arrow right make
    add(8'hF0, 4'h0, 1'b0, 4'h3);
    add(8'h1C, 4'h0, 1'b0, 4'h1);   // A break
    add(8'h5A, 4'h0, 1'b1, 4'h1);   // Enter
    add(8'h5A, 4'h0, 1'b1, 4'h1);   // Enter repeat still pulses
    add(8'hF0, 4'h0, 1'b0, 4'h1);
    add(8'h5A, 4'h0, 1'b0, 4'h1);   // Enter break ignored
    add(8'hE0, 4'h0, 1'b0, 4'h1);
    add(8'hF0, 4'h0, 1'b0, 4'h1);
    add(8'h74, 4'h0, 1'b0, 4'h0);
    add(8'h1D, 4'h8, 1'b0, 4'h8);   // W make
    add(8'hE0, 4'h0, 1'b0, 4'h8);
    add(8'h75, 4'h0, 1'b0, 4'h8);   // arrow up shares the held bit
    add(8'hF0, 4'h0, 1'b0, 4'h8);
    add(8'h1D, 4'h0, 1'b0, 4'h0);
    add(8'h72, 4'h0, 1'b0, 4'h0);   // non-extended 72 is unmapped
    add(8'h15, 4'h0, 1'b0, 4'h0);
    add(8'hE0, 4'h0, 1'b0, 4'h0);
    add(8'h15, 4'h0, 1'b0, 4'h0);   // unmapped extended
    add(8'hE0, 4'h0, 1'b0, 4'h0);
    add(8'h5A, 4'h0, 1'b0, 4'h0);   // keypad Enter is not start
    add(8'h1B, 4'h4, 1'b0, 4'h4);   // S make decoded from IDLE
    add(8'hF0, 4'h0, 1'b0, 4'h4);
    add(8'h1B, 4'h0, 1'b0, 4'h0);
    add(8'hE0, 4'h0, 1'b0, 4'h0);
    add(8'hE0, 4'h0, 1'b0, 4'h0);   // repeated E0 stays extended
    add(8'h6B, 4'h2, 1'b0, 4'h2);
    add(8'hF0, 4'h0, 1'b0, 4'h2);
    add(8'hE0, 4'h0, 1'b0, 4'h2);   // F0 E0 order also reaches EXT_BRK
    add(8'h6B, 4'h0, 1'b0, 4'h0);

    foreach (vecs[i])
      step(1'b0, 1'b1, vecs[i].code, vecs[i].exp, $sformatf("vec%0d_%h", i, vecs[i].code));
    step(1'b0, 1'b0, 8'h00, mk(4'h0, 1'b0, 4'h0), "after_table");

    // Dangling E0 times out, so 72 is then read as a plain unmapped byte.
    step(1'b0, 1'b1, 8'hE0, mk(4'h0, 1'b0, 4'h0), "tmo_prefix");
    for (int i = 1; i <= TMO; i++)
      step(1'b0, 1'b0, 8'h00, mk(4'h0, 1'b0, 4'h0), $sformatf("tmo_wait%0d", i));
    step(1'b0, 1'b1, 8'h72, mk(4'h0, 1'b0, 4'h0), "tmo_72");
    step(1'b0, 1'b1, 8'h1B, mk(4'h4, 1'b0, 4'h4), "tmo_idle_1b");
    step(1'b0, 1'b1, 8'hF0, mk(4'h0, 1'b0, 4'h4), "tmo_f0");
    step(1'b0, 1'b1, 8'h1B, mk(4'h0, 1'b0, 4'h0), "tmo_brk_1b");

    // Reset after F0 abandons the break.
    step(1'b0, 1'b1, 8'hF0, mk(4'h0, 1'b0, 4'h0), "rst_mid_f0");
    step(1'b1, 1'b0, 8'h00, mk(4'h0, 1'b0, 4'h0), "rst_mid_reset");
    step(1'b0, 1'b1, 8'h23, mk(4'h1, 1'b0, 4'h1), "rst_mid_23");
    step(1'b0, 1'b1, 8'hF0, mk(4'h0, 1'b0, 4'h1), "rst_mid_f0b");
    step(1'b0, 1'b1, 8'h23, mk(4'h0, 1'b0, 4'h0), "rst_mid_brk");

    // Reset clears held, and a tick in the reset cycle is dropped.
    step(1'b0, 1'b1, 8'h1D, mk(4'h8, 1'b0, 4'h8), "pre_rst_1d");
    step(1'b1, 1'b1, 8'h1B, mk(4'h0, 1'b0, 4'h0), "rst_with_tick");
    step(1'b0, 1'b1, 8'h1B, mk(4'h4, 1'b0, 4'h4), "post_rst_1b");
    step(1'b0, 1'b1, 8'hF0, mk(4'h0, 1'b0, 4'h4), "post_rst_f0");
    step(1'b0, 1'b1, 8'h1B, mk(4'h0, 1'b0, 4'h0), "post_rst_brk");

    // W held ~50 cycles: with auto-repeat, pulses at +1, +17, +33, +49.
    step(1'b0, 1'b1, 8'h1D, mk(4'h8, 1'b0, 4'h8), "rep_make");
    for (int c = 2; c <= 50; c++)
      step(1'b0, 1'b0, 8'h00,
           mk((REP_EN && (c % RP == 1)) ? 4'h8 : 4'h0, 1'b0, 4'h8), $sformatf("rep_c%0d", c));
    step(1'b0, 1'b1, 8'hF0, mk(4'h0, 1'b0, 4'h8), "rep_f0");
    step(1'b0, 1'b1, 8'h1D, mk(4'h0, 1'b0, 4'h0), "rep_brk");
    for (int c = 0; c < 40; c++)
      step(1'b0, 1'b0, 8'h00, mk(4'h0, 1'b0, 4'h0), $sformatf("rep_after%0d", c));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
